// File: rtl/bus_arbiter_2x1_pkg.sv
// Shared types for the 2:1 bus arbiter: bus width, FSM states
// and the round-robin pick used on grant and release.
package bus_arbiter_2x1_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10
  } state_t;

  // ls: last served, 0=A 1=B; a tie goes to the other side
  function automatic state_t arb_pick(
    input logic req_a,
    input logic req_b,
    input logic ls
  );
    state_t pick;
    pick = ST_IDLE;
    case ({req_a, req_b})
      2'b10:   pick = ST_OWN_A;
      2'b01:   pick = ST_OWN_B;
      2'b11:   pick = ls ? ST_OWN_A : ST_OWN_B;
      default: pick = ST_IDLE;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/bus_arbiter_2x1_mux.sv
// Plain 2:1 data mux; the arbiter drives its select from a register.
module bus_arbiter_2x1_mux #(
  parameter int W = 16
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/bus_arbiter_2x1.sv
// Round-robin owner of the shared 16-bit bus: fetch (A) vs data (B),
// released on the last accepted beat or after a bounded hold.
module bus_arbiter_2x1
  import bus_arbiter_2x1_pkg::*;
#(
  parameter int MAX_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_a,
  input  logic             i_req_b,
  input  logic [BUS_W-1:0] i_data_a,
  input  logic [BUS_W-1:0] i_data_b,
  input  logic             i_last_a,
  input  logic             i_last_b,
  input  logic             i_bus_ready,
  output logic [BUS_W-1:0] o_bus_data,
  output logic             o_bus_valid,
  output logic             o_bus_last,
  output logic             o_grant_a,
  output logic             o_grant_b,
  output logic             o_ready_a,
  output logic             o_ready_b,
  output logic             o_sel,
  output logic             o_timeout
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ls;
  logic             w_ls_nxt;
  logic             r_sel;
  logic             w_sel_nxt;
  logic             r_to;
  logic             w_to_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_own_a;
  logic w_own_b;
  logic w_owned;
  logic w_accept;
  logic w_done;
  logic w_expire;
  logic w_release;

  assign w_own_a = (r_state == ST_OWN_A);
  assign w_own_b = (r_state == ST_OWN_B);
  assign w_owned = w_own_a | w_own_b;

  assign o_bus_valid = (w_own_a & i_req_a)
                     | (w_own_b & i_req_b);
  assign o_bus_last  = (w_own_a & i_last_a)
                     | (w_own_b & i_last_b);
  assign o_ready_a   = w_own_a & i_req_a & i_bus_ready;
  assign o_ready_b   = w_own_b & i_req_b & i_bus_ready;

  assign w_accept  = o_bus_valid & i_bus_ready;
  assign w_done    = w_accept & o_bus_last;
  // a final beat on the last allowed cycle wins over the timeout
  assign w_expire  = w_owned & ~w_done
                   & (r_cnt == CNT_W'(MAX_CYCLES - 1));
  assign w_release = w_done | w_expire;

  always_comb begin
    w_state_nxt = r_state;
    w_ls_nxt    = r_ls;
    w_to_nxt    = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;

    if (r_state == ST_IDLE) begin
      w_state_nxt = arb_pick(i_req_a, i_req_b, r_ls);
    end else if (w_release) begin
      w_ls_nxt    = w_own_b;
      w_to_nxt    = w_expire;
      w_state_nxt = arb_pick(i_req_a, i_req_b, w_own_b);
    end

    if (w_state_nxt != ST_IDLE &&
        (r_state == ST_IDLE || w_release)) begin
      w_cnt_nxt = '0;
    end else if (w_owned) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end

    if (w_state_nxt == ST_OWN_A) begin
      w_sel_nxt = 1'b0;
    end else if (w_state_nxt == ST_OWN_B) begin
      w_sel_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_ls    <= 1'b1;
      r_sel   <= 1'b0;
      r_cnt   <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ls    <= w_ls_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign o_grant_a = w_own_a;
  assign o_grant_b = w_own_b;
  assign o_sel     = r_sel;
  assign o_timeout = r_to;

  bus_arbiter_2x1_mux #(
    .W(BUS_W)
  ) u_mux (
    .i_sel(r_sel),
    .i_d0 (i_data_a),
    .i_d1 (i_data_b),
    .o_y  (o_bus_data)
  );

endmodule

// File: tb/tb_bus_arbiter_2x1.sv
// Vector-table bench for bus_arbiter_2x1; expected outputs queued
// when each vector is driven and compared mid-cycle.
module tb_bus_arbiter_2x1;

  logic        clk;
  logic        rst;
  logic        req_a, req_b;
  logic [15:0] data_a, data_b;
  logic        last_a, last_b;
  logic        bus_ready;
  logic [15:0] bus_data;
  logic        bus_valid, bus_last;
  logic        grant_a, grant_b;
  logic        ready_a, ready_b;
  logic        sel, timeout;

  int total = 0;
  int bad   = 0;

  bus_arbiter_2x1 #(
    .MAX_CYCLES(16),
    .CNT_W     (5)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_req_a    (req_a),
    .i_req_b    (req_b),
    .i_data_a   (data_a),
    .i_data_b   (data_b),
    .i_last_a   (last_a),
    .i_last_b   (last_b),
    .i_bus_ready(bus_ready),
    .o_bus_data (bus_data),
    .o_bus_valid(bus_valid),
    .o_bus_last (bus_last),
    .o_grant_a  (grant_a),
    .o_grant_b  (grant_b),
    .o_ready_a  (ready_a),
    .o_ready_b  (ready_b),
    .o_sel      (sel),
    .o_timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in = {rst,ra,rb,la,lb,rdy}
  // ef = {ga,gb,sel,vld,lst,ya,yb,to}
  typedef struct {
    string       nm;
    logic [5:0]  in;
    logic [15:0] da;
    logic [15:0] db;
    logic [7:0]  ef;
  } vec_t;

  typedef struct {
    string       nm;
    logic [7:0]  ef;
    logic [15:0] ed;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(string nm, logic [5:0] in,
                              logic [15:0] da, logic [15:0] db,
                              logic [7:0] ef);
    vec_t v;
    v.nm = nm;
    v.in = in;
    v.da = da;
    v.db = db;
    v.ef = ef;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    {rst, req_a, req_b, last_a, last_b, bus_ready} = v.in;
    data_a = v.da;
    data_b = v.db;
    e.nm = v.nm;
    e.ef = v.ef;
    e.ed = v.ef[5] ? v.db : v.da;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [7:0] act;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    act = {grant_a, grant_b, sel, bus_valid, bus_last,
           ready_a, ready_b, timeout};
    total++;
    if (act !== e.ef || bus_data !== e.ed) begin
      bad++;
      $display("FAIL %s: got flags=%b data=%h want flags=%b data=%h",
               e.nm, act, bus_data, e.ef, e.ed);
    end
  endtask

  initial begin
    rst = 1'b1;
    {req_a, req_b, last_a, last_b, bus_ready} = '0;
    data_a = '0;
    data_b = '0;

    // single A beat, same-owner regrant, reset out of OWN_A
    vecs.push_back(mk("idle0",     6'b010101, 16'h1234, 16'h0, 8'b0000_0000));
    vecs.push_back(mk("a_beat",    6'b010101, 16'h1234, 16'h0, 8'b1001_1100));
    vecs.push_back(mk("a_regrant", 6'b000001, 16'h1234, 16'h0, 8'b1000_0000));
    vecs.push_back(mk("rst_a",     6'b100000, 16'h1234, 16'h0, 8'b1000_0000));
    vecs.push_back(mk("after_rst", 6'b000000, 16'h1234, 16'h0, 8'b0000_0000));
    // both requesting single beats: strict alternation
    vecs.push_back(mk("alt_idle", 6'b011111, 16'h1111, 16'h2222, 8'b0000_0000));
    vecs.push_back(mk("alt_a0",   6'b011111, 16'h1111, 16'h2222, 8'b1001_1100));
    vecs.push_back(mk("alt_b0",   6'b011111, 16'h1111, 16'h2222, 8'b0111_1010));
    vecs.push_back(mk("alt_a1",   6'b011111, 16'h1111, 16'h2222, 8'b1001_1100));
    vecs.push_back(mk("alt_b1",   6'b011111, 16'h1111, 16'h2222, 8'b0111_1010));
    vecs.push_back(mk("rst_alt",  6'b100000, 16'h1111, 16'h2222, 8'b1000_0000));
    // B three-beat burst with a stall, then handoff to A
    vecs.push_back(mk("brst_idle",  6'b001001, 16'h0, 16'h000A, 8'b0000_0000));
    vecs.push_back(mk("brst_b1",    6'b001001, 16'h0, 16'h000A, 8'b0111_0010));
    vecs.push_back(mk("brst_stall", 6'b001000, 16'h0, 16'h000B, 8'b0111_0000));
    vecs.push_back(mk("brst_b2",    6'b001001, 16'h0, 16'h000B, 8'b0111_0010));
    vecs.push_back(mk("brst_b3",    6'b011011, 16'h0, 16'h000C, 8'b0111_1010));
    vecs.push_back(mk("hand_a",     6'b010101, 16'h5555, 16'h0, 8'b1001_1100));
    vecs.push_back(mk("rst_brst",   6'b100000, 16'h5555, 16'h0, 8'b1000_0000));
    // A never finishes: forced release after 16 owned cycles
    vecs.push_back(mk("to_idle", 6'b010001, 16'hA0A0, 16'hB0B0, 8'b0000_0000));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk($sformatf("to_hold%0d", i), 6'b011001,
                        16'hA0A0 + 16'(i), 16'hB0B0, 8'b1001_0100));
    vecs.push_back(mk("to_b",    6'b001011, 16'hA0A0, 16'hB0B0, 8'b0111_1011));
    vecs.push_back(mk("rst_to",  6'b100000, 16'hA0A0, 16'hB0B0, 8'b0110_0000));
    // last beat on the final allowed cycle: normal handoff
    vecs.push_back(mk("cl_idle", 6'b011001, 16'hC0C0, 16'hD0D0, 8'b0000_0000));
    for (int i = 0; i < 15; i++)
      vecs.push_back(mk($sformatf("cl_hold%0d", i), 6'b011001,
                        16'hC0C0, 16'hD0D0 + 16'(i), 8'b1001_0100));
    vecs.push_back(mk("cl_last", 6'b011101, 16'hC0C0, 16'hD0D0, 8'b1001_1100));
    vecs.push_back(mk("cl_b",    6'b001000, 16'hC0C0, 16'hD0D0, 8'b0111_0000));
    // reset mid-burst of B, then A wins the first tie
    vecs.push_back(mk("rst_mid_b", 6'b101001, 16'hE0E0, 16'hF0F0, 8'b0111_0010));
    vecs.push_back(mk("post_idle", 6'b011001, 16'hE0E0, 16'hF0F0, 8'b0000_0000));
    vecs.push_back(mk("post_a",    6'b011101, 16'hE0E0, 16'hF0F0, 8'b1001_1100));

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check();
    end

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
